obi_xbar_rr: RTL and testbench
==============================

Name: obi_xbar_rr

Overview:
Parametrised OBI crossbar that replaces the fixed-priority SoC interconnect. It connects N_MASTERS core/debug/DMA masters to N_SLAVES memory-mapped slaves. Each slave has its own round-robin arbiter and a per-slave response-ID FIFO, so several transactions can be pipelined per slave. Addresses that match no slave are answered by an internal error responder. The block sits between tinyriscv_core and the rom/ram/peripheral slaves in the SoC top.

Parameters:
N_MASTERS, 2, number of master ports (1..8)
N_SLAVES, 2, number of slave ports (1..16)
MAX_OUTSTANDING, 2, granted-but-unanswered transactions tracked per slave and per master (power of 2, >=1)
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active low
m_req_i  in  [N_MASTERS] x 1  master request
m_gnt_o  out  [N_MASTERS] x 1  master grant
m_rvalid_o  out  [N_MASTERS] x 1  master response valid
m_err_o  out  [N_MASTERS] x 1  response error (unmapped address)
m_we_i  in  [N_MASTERS] x 1  write enable
m_be_i  in  [N_MASTERS] x DATA_W/8  byte enables
m_addr_i  in  [N_MASTERS] x ADDR_W  address
m_wdata_i  in  [N_MASTERS] x DATA_W  write data
m_rdata_o  out  [N_MASTERS] x DATA_W  read data
s_addr_mask_i  in  [N_SLAVES] x ADDR_W  decode mask
s_addr_base_i  in  [N_SLAVES] x ADDR_W  decode base
s_req_o  out  [N_SLAVES] x 1  slave request
s_gnt_i  in  [N_SLAVES] x 1  slave grant
s_rvalid_i  in  [N_SLAVES] x 1  slave response valid
s_we_o  out  [N_SLAVES] x 1  write enable
s_be_o  out  [N_SLAVES] x DATA_W/8  byte enables
s_addr_o  out  [N_SLAVES] x ADDR_W  address (unmodified)
s_wdata_o  out  [N_SLAVES] x DATA_W  write data
s_rdata_i  in  [N_SLAVES] x DATA_W  read data

Behaviour:
- Reset: one clock and a synchronous, active-low reset (rst_ni). All FIFOs are emptied, all RR pointers set to 0, all per-master outstanding counters cleared. During reset, all of m_gnt_o, m_rvalid_o, m_err_o and s_req_o are 0. m_rdata_o is 0 whenever m_rvalid_o=0.
- Decode (combinational): a master targets slave s when (addr & s_addr_mask_i[s]) == s_addr_base_i[s]. If several slaves match, the lowest index wins. If none match, the request goes to the internal error slave (index N_SLAVES).
- Arbitration: each slave has its own round-robin arbiter.
  - The winner is the first requesting master at or after ptr[s], searching modulo N_MASTERS.
  - s_req_o[s] is driven the same cycle the request arrives; there is zero added address-phase latency.
  - A master's req/addr/we/be/wdata are routed to s_*_o[s] only while that master is selected.
  - ptr[s] advances to winner+1 (wrapping) only on a cycle where s_gnt_i[s]=1. If there is no grant, the pointer holds, so the selection stays stable across slave back-pressure.
- Grant gating: m_gnt_o[m] = selected & s_gnt_i & both condition checks below pass.
  - The slave's ID FIFO is not full, or it is popping this same cycle.
  - The master's outstanding count is < MAX_OUTSTANDING, or it is decrementing this same cycle.
  - If the FIFO is blocked, s_req_o[s] is also forced to 0.
- Response routing:
  - On each slave grant, the winner's master ID is pushed into fifo[s].
  - On s_rvalid_i[s], the FIFO head selects the master. rvalid and rdata are forwarded combinationally, and the head is popped.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - An s_rvalid_i arriving with an empty FIFO is ignored; this is an assertion failure in simulation.
- In-order per master: a master may not be granted to a slave other than its last-granted slave while it has responses outstanding. This prevents reordering.
- Error slave:
  - Always grants, subject to the same gating.
  - Responds exactly 1 cycle after grant with m_rvalid_o=1, m_err_o=1, rdata=0.
  - Writes to it have no side effect.
  - It has its own ID FIFO of depth MAX_OUTSTANDING.
- Simultaneous events: in one cycle, a master may receive rvalid for an old transaction and gnt for a new one. Counter rule: next = cnt + gnt − rvalid.
- Reset mid-transaction: all tracking is discarded, and late slave responses after reset are ignored. Slaves share the same reset.
- N_MASTERS=1: the arbiter degenerates to a pass-through; the pointer is constant 0.

Decomposition:
- obi_pkg holds the following:
  - An obi_req_t struct: req, we, be, addr, wdata.
  - An obi_rsp_t struct: gnt, rvalid, err, rdata.
  - The localparam helpers MID_W = $clog2(N_MASTERS) and CNT_W = $clog2(MAX_OUTSTANDING+1).
- Sub-module obi_rr_arbiter (N inputs; req vector in, one-hot grant plus index out, pointer update on advance_i) is instantiated once per slave plus once for the error slave.
- The ID FIFO reuses the existing sync FIFO primitive.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles while m_req_i=2'b11 -> all gnt, rvalid, err and s_req stay 0. After release, the first grant goes to master 0.
- Contention: both masters request ram (0x1000_0000) continuously, ram grants every cycle -> grants alternate M0, M1, M0, M1. Each rvalid returns to the matching master with its own read data (0xAAAA_0000 vs 0x5555_0000).
- Back-pressure: ram holds s_gnt_i=0 for 4 cycles with M1 selected -> the selection stays M1, no m_gnt_o is asserted, ptr is unchanged, and M1 is granted first once the ram grants.
- Unmapped: M0 reads 0xF000_0000 -> gnt the same cycle; on the next cycle rvalid=1, err=1, rdata=0; no s_req_o is asserted.
- Outstanding limit: MAX_OUTSTANDING=2, rom delays rvalid by 3 cycles -> the third M1 request is not granted until the first rvalid arrives. A grant in the same cycle as that rvalid is accepted.
- Ordering: M0 issues a rom read then a ram read with the rom read still outstanding -> the ram request is held until the rom response returns, and responses arrive in issue order.

Source files
------------

// File: rtl/obi_pkg.sv
// Shared OBI bus types and width helpers for the round-robin crossbar.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;

    typedef struct packed {
        logic                      req;
        logic                      we;
        logic [OBI_DATA_W/8-1:0]   be;
        logic [OBI_ADDR_W-1:0]     addr;
        logic [OBI_DATA_W-1:0]     wdata;
    } obi_req_t;

    typedef struct packed {
        logic                      gnt;
        logic                      rvalid;
        logic                      err;
        logic [OBI_DATA_W-1:0]     rdata;
    } obi_rsp_t;

    // Index width, kept at least one bit so single-entry cases still have a signal.
    function automatic int unsigned mid_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; ptr moves past the winner on advance.
module obi_rr_arbiter
    import obi_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = mid_w(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr;
    int unsigned   k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = i + 32'(ptr);
            if (k >= N) k = k - N;
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

    // With N == 1 the wrap test always fires, so ptr stays 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (advance_i && valid_o) begin
            ptr <= (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/obi_sync_fifo.sv
// Synchronous FIFO; push while full is legal only together with a pop.
module obi_sync_fifo
    import obi_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = mid_w(DEPTH),
    localparam int unsigned CW = cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rptr;
    logic [AW-1:0]               wptr;
    logic [CW-1:0]               count;

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign data_o  = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push_i) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop_i) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            count <= count + CW'(push_i) - CW'(pop_i);
        end
    end

endmodule

// File: rtl/obi_xbar_rr.sv
// OBI crossbar: per-slave round-robin arbitration, per-slave response-ID FIFOs and an
// internal error slave (target index N_SLAVES) for unmapped addresses.
module obi_xbar_rr
    import obi_pkg::*;
#(
    parameter int unsigned N_MASTERS       = 2,
    parameter int unsigned N_SLAVES        = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [N_MASTERS-1:0]                  m_req_i,
    output logic [N_MASTERS-1:0]                  m_gnt_o,
    output logic [N_MASTERS-1:0]                  m_rvalid_o,
    output logic [N_MASTERS-1:0]                  m_err_o,
    input  logic [N_MASTERS-1:0]                  m_we_i,
    input  logic [N_MASTERS-1:0][DATA_W/8-1:0]    m_be_i,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0]      m_addr_i,
    input  logic [N_MASTERS-1:0][DATA_W-1:0]      m_wdata_i,
    output logic [N_MASTERS-1:0][DATA_W-1:0]      m_rdata_o,
    input  logic [N_SLAVES-1:0][ADDR_W-1:0]       s_addr_mask_i,
    input  logic [N_SLAVES-1:0][ADDR_W-1:0]       s_addr_base_i,
    output logic [N_SLAVES-1:0]                   s_req_o,
    input  logic [N_SLAVES-1:0]                   s_gnt_i,
    input  logic [N_SLAVES-1:0]                   s_rvalid_i,
    output logic [N_SLAVES-1:0]                   s_we_o,
    output logic [N_SLAVES-1:0][DATA_W/8-1:0]     s_be_o,
    output logic [N_SLAVES-1:0][ADDR_W-1:0]       s_addr_o,
    output logic [N_SLAVES-1:0][DATA_W-1:0]       s_wdata_o,
    input  logic [N_SLAVES-1:0][DATA_W-1:0]       s_rdata_i
);

    localparam int unsigned NT    = N_SLAVES + 1;
    localparam int unsigned TGT_W = mid_w(NT);
    localparam int unsigned MID_W = mid_w(N_MASTERS);
    localparam int unsigned CNT_W = cnt_w(MAX_OUTSTANDING);

    logic [N_MASTERS-1:0][TGT_W-1:0]  tgt;
    logic [N_MASTERS-1:0][TGT_W-1:0]  last_tgt;
    logic [N_MASTERS-1:0][CNT_W-1:0]  cnt;
    logic [N_MASTERS-1:0]             gnt_m;
    logic [N_MASTERS-1:0]             rvalid_m;
    logic [N_MASTERS-1:0]             err_m;
    logic [N_MASTERS-1:0][DATA_W-1:0] rdata_m;

    logic [NT-1:0][N_MASTERS-1:0]     treq;
    logic [NT-1:0][N_MASTERS-1:0]     sel;
    logic [NT-1:0][MID_W-1:0]         widx;
    logic [NT-1:0][MID_W-1:0]         head;
    logic [NT-1:0][DATA_W-1:0]        trdata;
    logic [NT-1:0]                    tvalid, tgnt_in, trvalid_in, full, empty;
    logic [NT-1:0]                    pop, blocked, treq_out, handshake;
    logic                             err_rvalid_q;

    obi_req_t [N_SLAVES-1:0]          sreq;
    obi_rsp_t [N_MASTERS-1:0]         mrsp;

    assign tgnt_in    = {1'b1, s_gnt_i};
    assign trvalid_in = {err_rvalid_q, s_rvalid_i};
    assign trdata     = {{DATA_W{1'b0}}, s_rdata_i};

    // Descending scan so the lowest matching slave index is the last one written.
    always_comb begin
        for (int unsigned m = 0; m < N_MASTERS; m++) begin
            tgt[m] = TGT_W'(N_SLAVES);
            for (int unsigned s = N_SLAVES; s > 0; s--) begin
                if ((m_addr_i[m] & s_addr_mask_i[s-1]) == s_addr_base_i[s-1]) begin
                    tgt[m] = TGT_W'(s - 1);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned t = 0; t < NT; t++) begin
            for (int unsigned m = 0; m < N_MASTERS; m++) begin
                treq[t][m] = rst_ni && m_req_i[m] && (tgt[m] == TGT_W'(t))
                          && ((cnt[m] == '0) || (last_tgt[m] == TGT_W'(t)))
                          && ((cnt[m] < CNT_W'(MAX_OUTSTANDING)) || rvalid_m[m]);
            end
        end
    end

    assign pop       = trvalid_in & ~empty & {NT{rst_ni}};
    assign blocked   = full & ~pop;
    assign treq_out  = tvalid & ~blocked;
    assign handshake = treq_out & tgnt_in;

    for (genvar t = 0; t < NT; t++) begin : g_tgt
        obi_rr_arbiter #(.N(N_MASTERS)) u_arb (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req_i     (treq[t]),
            .advance_i (handshake[t]),
            .gnt_o     (sel[t]),
            .idx_o     (widx[t]),
            .valid_o   (tvalid[t])
        );

        obi_sync_fifo #(.WIDTH(MID_W), .DEPTH(MAX_OUTSTANDING)) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (handshake[t]),
            .data_i  (widx[t]),
            .pop_i   (pop[t]),
            .data_o  (head[t]),
            .full_o  (full[t]),
            .empty_o (empty[t])
        );
    end

    always_comb begin
        rvalid_m = '0;
        err_m    = '0;
        rdata_m  = '0;
        for (int unsigned t = 0; t < NT; t++) begin
            for (int unsigned m = 0; m < N_MASTERS; m++) begin
                if (pop[t] && (head[t] == MID_W'(m))) begin
                    rvalid_m[m] = 1'b1;
                    err_m[m]    = (t == N_SLAVES);
                    rdata_m[m]  = trdata[t];
                end
            end
        end
    end

    always_comb begin
        gnt_m = '0;
        for (int unsigned t = 0; t < NT; t++) begin
            for (int unsigned m = 0; m < N_MASTERS; m++) begin
                if (handshake[t] && sel[t][m]) gnt_m[m] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < N_SLAVES; s++) begin
            sreq[s]     = '0;
            sreq[s].req = treq_out[s];
            for (int unsigned m = 0; m < N_MASTERS; m++) begin
                if (sel[s][m]) begin
                    sreq[s].we    = m_we_i[m];
                    sreq[s].be    = (OBI_DATA_W/8)'(m_be_i[m]);
                    sreq[s].addr  = OBI_ADDR_W'(m_addr_i[m]);
                    sreq[s].wdata = OBI_DATA_W'(m_wdata_i[m]);
                end
            end
            s_req_o[s]   = sreq[s].req;
            s_we_o[s]    = sreq[s].we;
            s_be_o[s]    = (DATA_W/8)'(sreq[s].be);
            s_addr_o[s]  = ADDR_W'(sreq[s].addr);
            s_wdata_o[s] = DATA_W'(sreq[s].wdata);
        end
    end

    always_comb begin
        for (int unsigned m = 0; m < N_MASTERS; m++) begin
            mrsp[m].gnt    = gnt_m[m];
            mrsp[m].rvalid = rvalid_m[m];
            mrsp[m].err    = err_m[m];
            mrsp[m].rdata  = OBI_DATA_W'(rdata_m[m]);
            m_gnt_o[m]     = mrsp[m].gnt;
            m_rvalid_o[m]  = mrsp[m].rvalid;
            m_err_o[m]     = mrsp[m].err;
            m_rdata_o[m]   = DATA_W'(mrsp[m].rdata);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt          <= '0;
            last_tgt     <= '0;
            err_rvalid_q <= 1'b0;
        end else begin
            err_rvalid_q <= handshake[N_SLAVES];
            for (int unsigned m = 0; m < N_MASTERS; m++) begin
                cnt[m] <= cnt[m] + CNT_W'(gnt_m[m]) - CNT_W'(rvalid_m[m]);
                if (gnt_m[m]) last_tgt[m] <= tgt[m];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int unsigned t = 0; t < NT; t++) begin
                assert (!(trvalid_in[t] && empty[t]));
            end
        end
    end

endmodule

// File: tb/tb_obi_xbar_rr.sv
// Directed bench for obi_xbar_rr: slave 0 = rom (0x0xxx_xxxx), slave 1 = ram (0x1xxx_xxxx).
module tb_obi_xbar_rr;

    localparam logic [31:0] RAM0 = 32'h1000_0000;
    localparam logic [31:0] RAM1 = 32'h1000_0004;
    localparam logic [31:0] RAMD = 32'h1000_0200;
    localparam logic [31:0] ROM0 = 32'h0000_0200;
    localparam logic [31:0] ROM1 = 32'h0000_0100;
    localparam logic [31:0] BAD  = 32'hF000_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       m_req, m_gnt, m_rvalid, m_err, m_we;
    logic [1:0][3:0]  m_be;
    logic [1:0][31:0] m_addr, m_wdata, m_rdata;
    logic [1:0][31:0] s_mask, s_base;
    logic [1:0]       s_req, s_gnt, s_rvalid, s_we;
    logic [1:0][3:0]  s_be;
    logic [1:0][31:0] s_addr, s_wdata, s_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic [1:0]  sgnt, srv;
        logic [31:0] rd0, rd1;
        logic [1:0]  gnt, sreq, rv, err;
        logic [31:0] d0, d1, sa1;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    obi_xbar_rr #(
        .N_MASTERS(2), .N_SLAVES(2), .MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .m_req_i       (m_req),
        .m_gnt_o       (m_gnt),
        .m_rvalid_o    (m_rvalid),
        .m_err_o       (m_err),
        .m_we_i        (m_we),
        .m_be_i        (m_be),
        .m_addr_i      (m_addr),
        .m_wdata_i     (m_wdata),
        .m_rdata_o     (m_rdata),
        .s_addr_mask_i (s_mask),
        .s_addr_base_i (s_base),
        .s_req_o       (s_req),
        .s_gnt_i       (s_gnt),
        .s_rvalid_i    (s_rvalid),
        .s_we_o        (s_we),
        .s_be_o        (s_be),
        .s_addr_o      (s_addr),
        .s_wdata_o     (s_wdata),
        .s_rdata_i     (s_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic rst, input logic [1:0] req,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic [1:0] sgnt, input logic [1:0] srv,
        input logic [31:0] rd0, input logic [31:0] rd1,
        input logic [1:0] gnt, input logic [1:0] sreq,
        input logic [1:0] rv, input logic [1:0] err,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] sa1);
        vec_t v;
        v.name = nm; v.rst = rst; v.req = req; v.a0 = a0; v.a1 = a1;
        v.sgnt = sgnt; v.srv = srv; v.rd0 = rd0; v.rd1 = rd1;
        v.gnt = gnt; v.sreq = sreq; v.rv = rv; v.err = err;
        v.d0 = d0; v.d1 = d1; v.sa1 = sa1;
        return v;
    endfunction

    initial begin
        s_mask   = {32'hF000_0000, 32'hF000_0000};
        s_base   = {32'h1000_0000, 32'h0000_0000};
        rst_n    = 1'b0;
        m_req    = '0; m_we = '0; m_be = '1; m_addr = '0; m_wdata = '0;
        s_gnt    = '0; s_rvalid = '0; s_rdata = '0;

        //                name  rst req    a0    a1    sgnt   srv    rd0            rd1             gnt    sreq   rv     err    d0             d1             sa1
        vecs.push_back(mk("R1", 0, 2'b11, RAM0, RAM1, 2'b11, 2'b00, 0,             0,              2'b00, 2'b00, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("R2", 0, 2'b11, RAM0, RAM1, 2'b11, 2'b00, 0,             0,              2'b00, 2'b00, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("R3", 0, 2'b11, RAM0, RAM1, 2'b11, 2'b00, 0,             0,              2'b00, 2'b00, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("C1", 1, 2'b11, RAM0, RAM1, 2'b10, 2'b00, 32'h0BAD_0BAD, 0,              2'b01, 2'b10, 2'b00, 2'b00, 0,             0,             RAM0));
        vecs.push_back(mk("C2", 1, 2'b11, RAM0, RAM1, 2'b10, 2'b10, 32'h0BAD_0BAD, 32'hAAAA_0000,  2'b10, 2'b10, 2'b01, 2'b00, 32'hAAAA_0000, 0,             RAM1));
        vecs.push_back(mk("C3", 1, 2'b11, RAM0, RAM1, 2'b10, 2'b10, 0,             32'h5555_0000,  2'b01, 2'b10, 2'b10, 2'b00, 0,             32'h5555_0000, RAM0));
        vecs.push_back(mk("C4", 1, 2'b11, RAM0, RAM1, 2'b10, 2'b10, 0,             32'hAAAA_0000,  2'b10, 2'b10, 2'b01, 2'b00, 32'hAAAA_0000, 0,             RAM1));
        vecs.push_back(mk("C5", 1, 2'b11, RAM0, RAM1, 2'b10, 2'b10, 0,             32'h5555_0000,  2'b01, 2'b10, 2'b10, 2'b00, 0,             32'h5555_0000, RAM0));
        vecs.push_back(mk("B1", 1, 2'b11, RAM0, RAM1, 2'b00, 2'b10, 0,             32'hAAAA_0000,  2'b00, 2'b10, 2'b01, 2'b00, 32'hAAAA_0000, 0,             RAM1));
        vecs.push_back(mk("B2", 1, 2'b11, RAM0, RAM1, 2'b00, 2'b00, 0,             32'h0BAD_0BAD,  2'b00, 2'b10, 2'b00, 2'b00, 0,             0,             RAM1));
        vecs.push_back(mk("B3", 1, 2'b11, RAM0, RAM1, 2'b00, 2'b00, 0,             0,              2'b00, 2'b10, 2'b00, 2'b00, 0,             0,             RAM1));
        vecs.push_back(mk("B4", 1, 2'b11, RAM0, RAM1, 2'b00, 2'b00, 0,             0,              2'b00, 2'b10, 2'b00, 2'b00, 0,             0,             RAM1));
        vecs.push_back(mk("B5", 1, 2'b11, RAM0, RAM1, 2'b10, 2'b00, 0,             0,              2'b10, 2'b10, 2'b00, 2'b00, 0,             0,             RAM1));
        vecs.push_back(mk("B6", 1, 2'b00, RAM0, RAM1, 2'b10, 2'b10, 0,             32'h5555_1111,  2'b00, 2'b00, 2'b10, 2'b00, 0,             32'h5555_1111, 0));
        vecs.push_back(mk("U1", 1, 2'b01, BAD,  RAM1, 2'b11, 2'b00, 0,             0,              2'b01, 2'b00, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("U2", 1, 2'b00, BAD,  RAM1, 2'b11, 2'b00, 32'h0BAD_0BAD, 32'h0BAD_0BAD,  2'b00, 2'b00, 2'b01, 2'b01, 0,             0,             0));
        vecs.push_back(mk("O1", 1, 2'b10, RAM0, ROM1, 2'b01, 2'b00, 0,             0,              2'b10, 2'b01, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("O2", 1, 2'b10, RAM0, ROM1, 2'b01, 2'b00, 0,             0,              2'b10, 2'b01, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("O3", 1, 2'b10, RAM0, ROM1, 2'b01, 2'b00, 0,             0,              2'b00, 2'b00, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("O4", 1, 2'b10, RAM0, ROM1, 2'b01, 2'b01, 32'h1234_5678, 0,              2'b10, 2'b01, 2'b10, 2'b00, 0,             32'h1234_5678, 0));
        vecs.push_back(mk("O5", 1, 2'b00, RAM0, ROM1, 2'b01, 2'b01, 32'h1234_0002, 0,              2'b00, 2'b00, 2'b10, 2'b00, 0,             32'h1234_0002, 0));
        vecs.push_back(mk("O6", 1, 2'b00, RAM0, ROM1, 2'b01, 2'b01, 32'h1234_0003, 0,              2'b00, 2'b00, 2'b10, 2'b00, 0,             32'h1234_0003, 0));
        vecs.push_back(mk("D1", 1, 2'b01, ROM0, RAM1, 2'b11, 2'b00, 0,             0,              2'b01, 2'b01, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("D2", 1, 2'b01, RAMD, RAM1, 2'b11, 2'b00, 0,             0,              2'b00, 2'b00, 2'b00, 2'b00, 0,             0,             0));
        vecs.push_back(mk("D3", 1, 2'b01, RAMD, RAM1, 2'b11, 2'b01, 32'hBEEF_0001, 0,              2'b00, 2'b00, 2'b01, 2'b00, 32'hBEEF_0001, 0,             0));
        vecs.push_back(mk("D4", 1, 2'b01, RAMD, RAM1, 2'b11, 2'b00, 0,             0,              2'b01, 2'b10, 2'b00, 2'b00, 0,             0,             RAMD));
        vecs.push_back(mk("D5", 1, 2'b00, RAMD, RAM1, 2'b11, 2'b10, 0,             32'hCAFE_0002,  2'b00, 2'b00, 2'b01, 2'b00, 32'hCAFE_0002, 0,             0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n      = vecs[i].rst;
            m_req      = vecs[i].req;
            m_addr[0]  = vecs[i].a0;
            m_addr[1]  = vecs[i].a1;
            m_we       = '0;
            m_be       = '1;
            m_wdata    = '0;
            s_gnt      = vecs[i].sgnt;
            s_rvalid   = vecs[i].srv;
            s_rdata[0] = vecs[i].rd0;
            s_rdata[1] = vecs[i].rd1;
            #4;
            chk({vecs[i].name, ".m_gnt"},    32'(m_gnt),    32'(vecs[i].gnt));
            chk({vecs[i].name, ".s_req"},    32'(s_req),    32'(vecs[i].sreq));
            chk({vecs[i].name, ".m_rvalid"}, 32'(m_rvalid), 32'(vecs[i].rv));
            chk({vecs[i].name, ".m_err"},    32'(m_err),    32'(vecs[i].err));
            chk({vecs[i].name, ".rdata0"},   m_rdata[0],    vecs[i].d0);
            chk({vecs[i].name, ".rdata1"},   m_rdata[1],    vecs[i].d1);
            chk({vecs[i].name, ".ram_addr"}, s_addr[1],     vecs[i].sa1);
        end

        // Write routing: M1 partial-byte write to ram.
        @(negedge clk);
        m_req = 2'b10; m_addr[1] = 32'h1000_0010; m_we = 2'b10;
        m_be[1] = 4'b0011; m_wdata[1] = 32'hDEAD_BEEF;
        s_gnt = 2'b10; s_rvalid = '0;
        #4;
        chk("WR.m_gnt",   32'(m_gnt),     32'h2);
        chk("WR.s_req",   32'(s_req),     32'h2);
        chk("WR.s_we",    32'(s_we[1]),   32'h1);
        chk("WR.s_be",    32'(s_be[1]),   32'h3);
        chk("WR.s_wdata", s_wdata[1],     32'hDEAD_BEEF);
        chk("WR.s_addr",  s_addr[1],      32'h1000_0010);
        @(negedge clk);
        m_req = '0; m_we = '0; s_rvalid = 2'b10; s_rdata[1] = '0;
        #4;
        chk("WR.rvalid",  32'(m_rvalid),  32'h2);
        chk("WR.err",     32'(m_err),     32'h0);

        // Unmapped write from M1: granted with no slave request, errored one cycle later.
        @(negedge clk);
        m_req = 2'b10; m_addr[1] = BAD; m_we = 2'b10; s_gnt = '0; s_rvalid = '0;
        #4;
        chk("UW.m_gnt",   32'(m_gnt),     32'h2);
        chk("UW.s_req",   32'(s_req),     32'h0);
        @(negedge clk);
        m_req = '0; m_we = '0;
        #4;
        chk("UW.rvalid",  32'(m_rvalid),  32'h2);
        chk("UW.err",     32'(m_err),     32'h2);
        chk("UW.rdata",   m_rdata[1],     32'h0);
        @(negedge clk);
        #4;
        chk("UW.idle",    32'(m_rvalid),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
